// File: rtl/cache_pkg.sv
// Shared encodings for the cache CPU-side request port and the traffic
// generator that drives it.
//   OP_RD / OP_WR     : request opcode on 'op'
//   SZ_B / SZ_H / SZ_W: access size on 'wsize' (byte, half, word)
//   gen_state_t       : traffic generator sequencing states
package cache_pkg;

  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_WR_GAP,
    S_RD,
    S_RD_GAP,
    S_DONE
  } gen_state_t;

endpackage

// File: rtl/cache_byte_mask.sv
// Byte-lane selection for a CPU-side access. Also used by the cache
// store-merge path.
//   wsize   in  2   access size (SZ_B / SZ_H / SZ_W; 3 treated as word)
//   addr_lo in  2   address bits [1:0]
//   strb    out 4   one bit per addressed byte lane
//   mask    out 32  strb expanded to bit granularity
module cache_byte_mask
  import cache_pkg::*;
(
  input  logic [1:0]  wsize,
  input  logic [1:0]  addr_lo,
  output logic [3:0]  strb,
  output logic [31:0] mask
);

  always_comb begin
    strb = '0;
    mask = '0;
    case (wsize)
      SZ_B:    strb = 4'b0001 << addr_lo;
      // halfword lane pair follows addr[1] only; addr[0] misalignment is
      // left for the cache to define
      SZ_H:    strb = addr_lo[1] ? 4'b1100 : 4'b0011;
      default: strb = 4'b1111;
    endcase
    for (int unsigned k = 0; k < 4; k++) begin
      mask[8*k +: 8] = {8{strb[k]}};
    end
  end

endmodule

// File: rtl/cache_traffic_gen.sv
// Self-checking request generator for the cache CPU-side port. A start pulse
// issues NUM_OPS writes of data_i = SEED + i*INCR at addr_i = BASE_ADDR +
// i*STRIDE, then reads the same sequence back and checks the addressed lanes.
//   clk, resetn (sync, active low), start (pulse)
//   busy, done, pass, timeout          : run status
//   err_count, fail_addr, fail_data    : mismatch count and first-mismatch capture
//   op, valid, addr, wsize, wdata      : request port (all registered)
//   rdata_valid, wdata_valid, rdata    : completions from the cache
module cache_traffic_gen
  import cache_pkg::*;
#(
  parameter int unsigned NUM_OPS   = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0020,
  parameter logic [31:0] STRIDE    = 32'd4,
  parameter logic [1:0]  WSIZE     = 2'd2,
  parameter logic [31:0] SEED      = 32'hAAAA_AAAA,
  parameter logic [31:0] INCR      = 32'h1111_1111,
  parameter int unsigned TIMEOUT   = 256
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [15:0] err_count,
  output logic [31:0] fail_addr,
  output logic [31:0] fail_data,
  output logic        op,
  output logic        valid,
  output logic [31:0] addr,
  output logic [1:0]  wsize,
  output logic [31:0] wdata,
  input  logic        rdata_valid,
  input  logic        wdata_valid,
  input  logic [31:0] rdata
);

  localparam logic [15:0] LAST_IDX = 16'(NUM_OPS - 1);
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 1);

  gen_state_t  state;
  logic [15:0] idx;
  logic [31:0] tcnt;

  logic [3:0]  strb;
  logic [31:0] mask;
  logic [31:0] exp_sh;
  logic        mismatch;

  cache_byte_mask u_mask (
    .wsize   (WSIZE),
    .addr_lo (addr[1:0]),
    .strb    (strb),
    .mask    (mask)
  );

  // addr/wdata registers double as the running addr_i/data_i; the expected
  // value is placed starting at the lowest addressed lane.
  always_comb begin
    exp_sh = wdata;
    if (strb[0])      exp_sh = wdata;
    else if (strb[1]) exp_sh = wdata << 8;
    else if (strb[2]) exp_sh = wdata << 16;
    else              exp_sh = wdata << 24;
    mismatch = |((rdata ^ exp_sh) & mask);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      timeout   <= 1'b0;
      err_count <= '0;
      fail_addr <= '0;
      fail_data <= '0;
      op        <= 1'b0;
      valid     <= 1'b0;
      addr      <= '0;
      wsize     <= WSIZE;
      wdata     <= '0;
      idx       <= '0;
      tcnt      <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state     <= S_WR;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            timeout   <= 1'b0;
            err_count <= '0;
            fail_addr <= '0;
            fail_data <= '0;
            op        <= OP_WR;
            valid     <= 1'b1;
            addr      <= BASE_ADDR;
            wdata     <= SEED;
            idx       <= '0;
            tcnt      <= '0;
          end
        end

        S_WR: begin
          if (valid && wdata_valid) begin
            state <= S_WR_GAP;
            valid <= 1'b0;
          end else if (tcnt == TMO_LAST) begin
            state   <= S_DONE;
            timeout <= 1'b1;
            valid   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            pass    <= 1'b0;
          end else begin
            tcnt <= tcnt + 32'd1;
          end
        end

        S_WR_GAP: begin
          valid <= 1'b1;
          tcnt  <= '0;
          if (idx == LAST_IDX) begin
            state <= S_RD;
            op    <= OP_RD;
            idx   <= '0;
            addr  <= BASE_ADDR;
            wdata <= SEED;
          end else begin
            state <= S_WR;
            idx   <= idx + 16'd1;
            addr  <= addr + STRIDE;
            wdata <= wdata + INCR;
          end
        end

        S_RD: begin
          if (valid && rdata_valid) begin
            state <= S_RD_GAP;
            valid <= 1'b0;
            if (mismatch) begin
              if (err_count == '0) begin
                fail_addr <= addr;
                fail_data <= rdata;
              end
              if (err_count != '1) begin
                err_count <= err_count + 16'd1;
              end
            end
          end else if (tcnt == TMO_LAST) begin
            state   <= S_DONE;
            timeout <= 1'b1;
            valid   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            pass    <= 1'b0;
          end else begin
            tcnt <= tcnt + 32'd1;
          end
        end

        S_RD_GAP: begin
          if (idx == LAST_IDX) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_count == '0) && !timeout;
          end else begin
            state <= S_RD;
            valid <= 1'b1;
            tcnt  <= '0;
            idx   <= idx + 16'd1;
            addr  <= addr + STRIDE;
            wdata <= wdata + INCR;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_traffic_gen.sv
// Bench for cache_traffic_gen: a word-mode instance (u_w) and a byte-mode
// instance (u_b) driven by a shared memory responder with optional
// corruption, spurious completions and a never-respond mode.
module tb_cache_traffic_gen;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic        start_s[2], busy_s[2], done_s[2], pass_s[2], timeout_s[2];
  logic        op_s[2], valid_s[2], rv_s[2], wv_s[2];
  logic [15:0] err_s[2];
  logic [31:0] faddr_s[2], fdata_s[2], addr_s[2], wdata_s[2], rdata_s[2];
  logic [1:0]  wsize_s[2];

  int unsigned cfg_n[2]      = '{4, 8};
  logic [31:0] cfg_base[2]   = '{32'h20, 32'h40};
  logic [31:0] cfg_stride[2] = '{32'd4, 32'd1};
  logic [1:0]  cfg_wsz[2]    = '{2'd2, 2'd0};
  localparam logic [31:0] SEED = 32'hAAAA_AAAA;
  localparam logic [31:0] INCR = 32'h1111_1111;

  cache_traffic_gen #(.TIMEOUT(16)) u_w (
    .clk(clk), .resetn(resetn), .start(start_s[0]), .busy(busy_s[0]),
    .done(done_s[0]), .pass(pass_s[0]), .timeout(timeout_s[0]),
    .err_count(err_s[0]), .fail_addr(faddr_s[0]), .fail_data(fdata_s[0]),
    .op(op_s[0]), .valid(valid_s[0]), .addr(addr_s[0]), .wsize(wsize_s[0]),
    .wdata(wdata_s[0]), .rdata_valid(rv_s[0]), .wdata_valid(wv_s[0]),
    .rdata(rdata_s[0])
  );

  cache_traffic_gen #(.NUM_OPS(8), .BASE_ADDR(32'h40), .STRIDE(32'd1),
                      .WSIZE(2'd0), .TIMEOUT(16)) u_b (
    .clk(clk), .resetn(resetn), .start(start_s[1]), .busy(busy_s[1]),
    .done(done_s[1]), .pass(pass_s[1]), .timeout(timeout_s[1]),
    .err_count(err_s[1]), .fail_addr(faddr_s[1]), .fail_data(fdata_s[1]),
    .op(op_s[1]), .valid(valid_s[1]), .addr(addr_s[1]), .wsize(wsize_s[1]),
    .wdata(wdata_s[1]), .rdata_valid(rv_s[1]), .wdata_valid(wv_s[1]),
    .rdata(rdata_s[1])
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  typedef struct {
    int          d;
    logic        op;
    logic [31:0] addr;
    logic [31:0] data;
  } req_t;
  req_t sbq[$];

  // responder state
  int          mode[2];     // 0 = respond, 1 = never respond
  bit          spur[2];     // drive wrong/idle completions
  bit          c_en[2], c_all[2];
  logic [31:0] c_addr[2], c_mask[2], c_val[2];
  int          wcnt[2], lat[2], nreq[2];
  logic [31:0] mem [bit [31:0]];

  function automatic bit [31:0] mkey(input int d, input logic [31:0] a);
    return (32'(d) << 28) | (a >> 2);
  endfunction

  function automatic logic [31:0] lane_mask(input logic [1:0] sz, input logic [1:0] lo);
    logic [31:0] m;
    case (sz)
      2'd0:    m = 32'h0000_00FF << (8 * lo);
      2'd1:    m = lo[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
      default: m = 32'hFFFF_FFFF;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] place(input logic [1:0] sz, input logic [1:0] lo,
                                        input logic [31:0] v);
    logic [31:0] r;
    case (sz)
      2'd0:    r = v << (8 * lo);
      2'd1:    r = lo[1] ? (v << 16) : v;
      default: r = v;
    endcase
    return r;
  endfunction

  task automatic sb_check(input int d);
    req_t e;
    chk("sb_nonempty", 32'(sbq.size() > 0), 32'd1);
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("sb_dut", 32'(d), 32'(e.d));
      chk("sb_op", {31'd0, op_s[d]}, {31'd0, e.op});
      chk("sb_addr", addr_s[d], e.addr);
      chk("sb_wsize", {30'd0, wsize_s[d]}, {30'd0, cfg_wsz[d]});
      if (e.op) chk("sb_wdata", wdata_s[d], e.data);
    end
  endtask

  initial begin
    logic [31:0] k, m, w;
    for (int d = 0; d < 2; d++) begin
      wv_s[d] = 1'b0; rv_s[d] = 1'b0; rdata_s[d] = '0;
      wcnt[d] = 0; lat[d] = 1; nreq[d] = 0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        wv_s[d] = 1'b0;
        rv_s[d] = 1'b0;
        if (!resetn) begin
          wcnt[d] = 0;
        end else if (valid_s[d] && mode[d] == 0) begin
          if (wcnt[d] >= lat[d]) begin
            sb_check(d);
            k = mkey(d, addr_s[d]);
            w = mem.exists(k) ? mem[k] : 32'd0;
            if (op_s[d]) begin
              m = lane_mask(cfg_wsz[d], addr_s[d][1:0]);
              mem[k] = (w & ~m) | (place(cfg_wsz[d], addr_s[d][1:0], wdata_s[d]) & m);
              wv_s[d] = 1'b1;
            end else begin
              if (c_all[d] || (c_en[d] && addr_s[d] == c_addr[d]))
                w = (w & ~c_mask[d]) | (c_val[d] & c_mask[d]);
              rdata_s[d] = w;
              rv_s[d] = 1'b1;
            end
            wcnt[d] = 0;
            nreq[d]++;
            lat[d] = nreq[d] % 3;
          end else begin
            if (spur[d]) begin
              if (op_s[d]) rv_s[d] = 1'b1;
              else         wv_s[d] = 1'b1;
            end
            wcnt[d]++;
          end
        end else if (!valid_s[d] && spur[d]) begin
          wv_s[d] = 1'b1;
          rv_s[d] = 1'b1;
        end
      end
    end
  end

  task automatic start_run(input int d);
    logic [31:0] a, v;
    sbq.delete();
    for (int ph = 1; ph >= 0; ph--) begin
      a = cfg_base[d];
      v = SEED;
      for (int unsigned i = 0; i < cfg_n[d]; i++) begin
        sbq.push_back('{d: d, op: ph[0], addr: a, data: v});
        a = a + cfg_stride[d];
        v = v + INCR;
      end
    end
    @(negedge clk);
    start_s[d] = 1'b1;
    @(negedge clk);
    start_s[d] = 1'b0;
  endtask

  task automatic wait_done(input int d, input int budget);
    int n = 0;
    while (!done_s[d] && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("done_wait", {31'd0, done_s[d]}, 32'd1);
  endtask

  task automatic check_end(input int d, input logic p, input logic [15:0] e,
                           input logic to, input logic [31:0] fa, input logic [31:0] fd);
    chk("end_done", {31'd0, done_s[d]}, 32'd1);
    chk("end_busy", {31'd0, busy_s[d]}, 32'd0);
    chk("end_valid", {31'd0, valid_s[d]}, 32'd0);
    chk("end_pass", {31'd0, pass_s[d]}, {31'd0, p});
    chk("end_err", {16'd0, err_s[d]}, {16'd0, e});
    chk("end_timeout", {31'd0, timeout_s[d]}, {31'd0, to});
    chk("end_fail_addr", faddr_s[d], fa);
    chk("end_fail_data", fdata_s[d], fd);
    chk("end_sb_drained", 32'(sbq.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    resetn = 1'b0;
    for (int d = 0; d < 2; d++) begin
      start_s[d] = 1'b0; mode[d] = 0; spur[d] = 1'b0;
      c_en[d] = 1'b0; c_all[d] = 1'b0;
      c_addr[d] = '0; c_mask[d] = '0; c_val[d] = '0;
    end
    repeat (3) @(negedge clk);

    // reset state
    for (int d = 0; d < 2; d++) begin
      chk("rst_valid", {31'd0, valid_s[d]}, 32'd0);
      chk("rst_busy", {31'd0, busy_s[d]}, 32'd0);
      chk("rst_done", {31'd0, done_s[d]}, 32'd0);
      chk("rst_pass", {31'd0, pass_s[d]}, 32'd0);
      chk("rst_timeout", {31'd0, timeout_s[d]}, 32'd0);
      chk("rst_err", {16'd0, err_s[d]}, 32'd0);
      chk("rst_addr", addr_s[d], 32'd0);
      chk("rst_wdata", wdata_s[d], 32'd0);
      chk("rst_wsize", {30'd0, wsize_s[d]}, {30'd0, cfg_wsz[d]});
    end
    resetn = 1'b1;

    // word mode, clean memory
    start_run(0);
    wait_done(0, 400);
    check_end(0, 1'b1, 16'd0, 1'b0, 32'd0, 32'd0);

    // word at 0x28 reads back as zero
    c_en[0] = 1'b1; c_addr[0] = 32'h28; c_mask[0] = '1; c_val[0] = '0;
    start_run(0);
    wait_done(0, 400);
    check_end(0, 1'b0, 16'd1, 1'b0, 32'h28, 32'h0);

    // restart from DONE clears status
    c_en[0] = 1'b0;
    start_run(0);
    chk("restart_busy", {31'd0, busy_s[0]}, 32'd1);
    chk("restart_done", {31'd0, done_s[0]}, 32'd0);
    chk("restart_pass", {31'd0, pass_s[0]}, 32'd0);
    chk("restart_err", {16'd0, err_s[0]}, 32'd0);
    chk("restart_fail_addr", faddr_s[0], 32'd0);
    chk("restart_fail_data", fdata_s[0], 32'd0);
    wait_done(0, 400);
    check_end(0, 1'b1, 16'd0, 1'b0, 32'd0, 32'd0);

    // start while busy, plus spurious/wrong-type completions
    spur[0] = 1'b1;
    start_run(0);
    repeat (3) @(negedge clk);
    start_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    wait_done(0, 400);
    check_end(0, 1'b1, 16'd0, 1'b0, 32'd0, 32'd0);
    spur[0] = 1'b0;

    // responder silent: timeout after 16 valid cycles
    mode[0] = 1;
    start_run(0);
    n = 0;
    while (valid_s[0] && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("tmo_valid_cycles", 32'(n), 32'd16);
    chk("tmo_timeout", {31'd0, timeout_s[0]}, 32'd1);
    chk("tmo_done", {31'd0, done_s[0]}, 32'd1);
    chk("tmo_pass", {31'd0, pass_s[0]}, 32'd0);
    chk("tmo_busy", {31'd0, busy_s[0]}, 32'd0);
    mode[0] = 0;
    start_run(0);
    chk("tmo_cleared", {31'd0, timeout_s[0]}, 32'd0);
    wait_done(0, 400);
    check_end(0, 1'b1, 16'd0, 1'b0, 32'd0, 32'd0);

    // reset pulse during the third write
    start_run(0);
    n = 0;
    while (!(valid_s[0] && op_s[0] && addr_s[0] == 32'h28) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rst3_reached_w3", addr_s[0], 32'h28);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    chk("rst3_valid", {31'd0, valid_s[0]}, 32'd0);
    chk("rst3_busy", {31'd0, busy_s[0]}, 32'd0);
    repeat (3) @(negedge clk);
    chk("rst3_idle_done", {31'd0, done_s[0]}, 32'd0);
    chk("rst3_idle_valid", {31'd0, valid_s[0]}, 32'd0);
    start_run(0);
    wait_done(0, 400);
    check_end(0, 1'b1, 16'd0, 1'b0, 32'd0, 32'd0);

    // byte mode, clean
    spur[1] = 1'b1;
    start_run(1);
    wait_done(1, 600);
    check_end(1, 1'b1, 16'd0, 1'b0, 32'd0, 32'd0);

    // byte mode: unaddressed lanes of the 0x42 read corrupted
    c_en[1] = 1'b1; c_addr[1] = 32'h42; c_mask[1] = 32'hFF00_FFFF; c_val[1] = '0;
    start_run(1);
    wait_done(1, 600);
    check_end(1, 1'b1, 16'd0, 1'b0, 32'd0, 32'd0);

    // byte mode: addressed lane of the 0x45 read corrupted
    // word 0x44 holds bytes EE,FF,10,21 -> 2110FFEE, lane 1 zeroed
    c_addr[1] = 32'h45; c_mask[1] = 32'h0000_FF00;
    start_run(1);
    wait_done(1, 600);
    check_end(1, 1'b0, 16'd1, 1'b0, 32'h45, 32'h2110_00EE);

    // byte mode: every read zeroed, only the first is captured
    c_en[1] = 1'b0; c_all[1] = 1'b1; c_mask[1] = '1; c_val[1] = '0;
    start_run(1);
    wait_done(1, 600);
    check_end(1, 1'b0, 16'd8, 1'b0, 32'h40, 32'h0);
    c_all[1] = 1'b0;
    spur[1] = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
